// File: rtl/clk_meas_pkg.sv
// -----------------------------------------------------------------------------
// clk_meas_pkg
// Shared definitions for the clock period meter: the measurement FSM state
// enumeration and the default counter width / timeout constants used as
// parameter defaults by clk_period_meter.
// -----------------------------------------------------------------------------
package clk_meas_pkg;

   // Default width of the measurement counter and of the published results
   localparam int CNT_W_DEF   = 16;

   // Default number of clk_in cycles without a rising edge before timeout
   localparam int TIMEOUT_DEF = 65535;

   // Measurement FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } meas_state_t;

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Brings the asynchronous square wave into the clk_in domain through a 2-flop
// synchronizer and detects its edges with one further history flop. The
// rise/fall pulses are combinational from the last two flops, so the FSM that
// samples them acts on the third clk_in edge after sig_in changes.
//
// Ports:
//   clk_in  - sole clock, rising edge
//   rst_n   - asynchronous active-low reset, clears all three flops
//   sig_in  - asynchronous input signal
//   rise    - one-cycle pulse, synchronized sig_in went 0 -> 1
//   fall    - one-cycle pulse, synchronized sig_in went 1 -> 0
// -----------------------------------------------------------------------------
module sync_edge (
   input  logic clk_in,
   input  logic rst_n,
   input  logic sig_in,
   output logic rise,
   output logic fall
);

   logic sync_1;
   logic sync_2;
   logic sync_prev;

   // Two metastability flops followed by one flop holding the previous
   // synchronized level for edge comparison
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         sync_prev <= 1'b0;
      end else begin
         sync_1    <= sig_in;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
      end
   end

   assign rise = sync_2 & ~sync_prev;
   assign fall = ~sync_2 & sync_prev;

endmodule

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
// Measures the period (rise to rise) and the high phase (rise to fall) of an
// asynchronous square wave, in clk_in cycles. Results update together with a
// one-cycle valid pulse; a sticky timeout flag reports a missing rising edge.
//
// Optional feature macro: CLK_PERIOD_METER_DUTY_EN
//   defined   - high phase is latched and published on high_time
//   undefined - no high-phase latch, high_time is constant 0
//
// Parameters:
//   CNT_W    - width of the counter and of period/high_time
//   TIMEOUT  - clk_in cycles without a rising edge before timeout (2..2^CNT_W-1)
//
// Ports:
//   clk_in    - sole clock, rising edge
//   rst_n     - asynchronous active-low reset
//   en        - measurement enable, synchronous to clk_in
//   sig_in    - measured square wave, asynchronous
//   period    - last measured period
//   high_time - last measured high phase
//   valid     - one-cycle pulse when period/high_time update
//   timeout   - sticky, set when TIMEOUT cycles pass with no rising edge
// -----------------------------------------------------------------------------
module clk_period_meter
   import clk_meas_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   meas_state_t      state;
   meas_state_t      state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic             rise;
   logic             fall;
   logic             publish;
   logic             set_timeout;
   logic             clr_timeout;
`ifdef CLK_PERIOD_METER_DUTY_EN
   logic             latch_high;
   logic             missed_fall;
   logic [CNT_W-1:0] high_lat;
`endif

   sync_edge u_sync_edge (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .sig_in (sig_in),
      .rise   (rise),
      .fall   (fall)
   );

   // Saturating increment so a stuck counter never wraps to a small value
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

   // Next-state logic. Disable has priority over everything, then a rising
   // edge, then timeout, then a falling edge. The counter is loaded to 1 on
   // the rise cycle so that its value on the next rise equals the number of
   // cycles between the two rises.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      publish     = 1'b0;
      set_timeout = 1'b0;
      clr_timeout = 1'b0;
`ifdef CLK_PERIOD_METER_DUTY_EN
      latch_high  = 1'b0;
      missed_fall = 1'b0;
`endif
      if (!en) begin
         state_nxt   = ST_IDLE;
         cnt_nxt     = '0;
         clr_timeout = 1'b1;
      end else begin
         unique case (state)
            ST_IDLE: begin
               state_nxt = ST_ARM;
               cnt_nxt   = '0;
            end
            ST_ARM: begin
               if (rise) begin
                  state_nxt = ST_HIGH;
                  cnt_nxt   = CNT_ONE;
               end else if (cnt == TO_VAL) begin
                  set_timeout = 1'b1;
                  cnt_nxt     = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            ST_HIGH: begin
               if (rise) begin
                  // Fall was never seen: whole period counts as high
                  publish = 1'b1;
                  cnt_nxt = CNT_ONE;
`ifdef CLK_PERIOD_METER_DUTY_EN
                  missed_fall = 1'b1;
`endif
               end else if (cnt == TO_VAL) begin
                  set_timeout = 1'b1;
                  state_nxt   = ST_ARM;
                  cnt_nxt     = '0;
               end else begin
                  cnt_nxt = cnt_inc;
                  if (fall) begin
                     state_nxt = ST_LOW;
`ifdef CLK_PERIOD_METER_DUTY_EN
                     latch_high = 1'b1;
`endif
                  end
               end
            end
            ST_LOW: begin
               if (rise) begin
                  publish   = 1'b1;
                  state_nxt = ST_HIGH;
                  cnt_nxt   = CNT_ONE;
               end else if (cnt == TO_VAL) begin
                  set_timeout = 1'b1;
                  state_nxt   = ST_ARM;
                  cnt_nxt     = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // State, counter and published results. Timeout set wins over clear
   // because both cannot happen in one cycle anyway (set needs en=1 and no
   // rise, clear needs a publish or en=0).
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         period  <= '0;
         valid   <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         valid <= publish;
         if (publish) begin
            period <= cnt;
         end
         if (set_timeout) begin
            timeout <= 1'b1;
         end else if (publish || clr_timeout) begin
            timeout <= 1'b0;
         end
      end
   end

`ifdef CLK_PERIOD_METER_DUTY_EN
   // High phase is latched on the fall and published on the following rise;
   // a rise with no fall in between publishes the full count as high time.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         high_lat  <= '0;
         high_time <= '0;
      end else begin
         if (latch_high) begin
            high_lat <= cnt;
         end
         if (publish) begin
            high_time <= missed_fall ? cnt : high_lat;
         end
      end
   end
`else
   assign high_time = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_period_meter
// Self-checking bench for clk_period_meter. A timestamp-based model tracks
// when synchronized rising/falling edges occur and derives the expected
// period, high time, valid and timeout from the cycle distances between them.
// Outputs are compared on every falling clock edge; directed scenarios add
// literal checks on reset values, divider patterns, timeout and enable/reset
// aborts, followed by randomized patterns.
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

   localparam int CNT_W = 16;
   localparam int TO    = 20;

   localparam logic [1:0] M_OFF  = 2'd0;
   localparam logic [1:0] M_WAIT = 2'd1;
   localparam logic [1:0] M_RUN  = 2'd2;

   typedef struct packed {
      logic [1:0]       mode;
      int               cyc;
      int               base;
      int               riseAt;
      int               highLat;
      logic             fallSeen;
      logic             s1;
      logic             s2;
      logic             s3;
      logic [CNT_W-1:0] expPeriod;
      logic [CNT_W-1:0] expHigh;
      logic             expValid;
      logic             expTimeout;
   } model_t;

   logic             clk_in = 1'b0;
   logic             rst_n  = 1'b0;
   logic             en     = 1'b0;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             timeout;

   int     vecCount  = 0;
   int     missCount = 0;
   int     validSeen = 0;
   model_t ms;

   always #5 clk_in = ~clk_in;

   clk_period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TO)
   ) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .en        (en),
      .sig_in    (sig_in),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .timeout   (timeout)
   );

   // One model step per clk_in edge. The input is seen by the meter three
   // sampled edges late; rise/fall are judged on the value sampled two edges
   // ago versus three edges ago. Counter ages are plain cycle differences.
   function automatic model_t stepModel(model_t m, logic enNow, logic sigNow);
      model_t n;
      logic   r;
      logic   f;
      int     p;
      int     age;
      n     = m;
      p     = m.cyc + 1;
      n.cyc = p;
      r     = m.s2 & ~m.s3;
      f     = ~m.s2 & m.s3;
      n.s3  = m.s2;
      n.s2  = m.s1;
      n.s1  = sigNow;
      n.expValid = 1'b0;
      if (!enNow) begin
         n.mode       = M_OFF;
         n.expTimeout = 1'b0;
      end else if (m.mode == M_OFF) begin
         n.mode = M_WAIT;
         n.base = p + 1;
      end else if (m.mode == M_WAIT) begin
         if (r) begin
            n.mode     = M_RUN;
            n.riseAt   = p;
            n.fallSeen = 1'b0;
         end else if (p - m.base == TO) begin
            n.expTimeout = 1'b1;
            n.base       = p + 1;
         end
      end else begin
         age = p - m.riseAt;
         if (r) begin
            n.expPeriod  = CNT_W'(age);
            n.expHigh    = m.fallSeen ? CNT_W'(m.highLat) : CNT_W'(age);
            n.expValid   = 1'b1;
            n.expTimeout = 1'b0;
            n.riseAt     = p;
            n.fallSeen   = 1'b0;
         end else if (age == TO) begin
            n.expTimeout = 1'b1;
            n.mode       = M_WAIT;
            n.base       = p + 1;
         end else if (f && !m.fallSeen) begin
            n.highLat  = age;
            n.fallSeen = 1'b1;
         end
      end
      return n;
   endfunction

   // Reference model state register
   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         ms <= '0;
      end else begin
         ms <= stepModel(ms, en, sig_in);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time,
                  actual, expected);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk_in) begin
      checkOutput("period", 32'(period), 32'(ms.expPeriod));
`ifdef CLK_PERIOD_METER_DUTY_EN
      checkOutput("high_time", 32'(high_time), 32'(ms.expHigh));
`else
      checkOutput("high_time", 32'(high_time), 32'd0);
`endif
      checkOutput("valid", 32'(valid), 32'(ms.expValid));
      checkOutput("timeout", 32'(timeout), 32'(ms.expTimeout));
      if (valid) begin
         validSeen++;
      end
   end

   task automatic tick();
      @(negedge clk_in);
      #1;
   endtask

   task automatic applyStimulus(input int hi, input int lo, input int reps);
      for (int r = 0; r < reps; r++) begin
         sig_in = 1'b1;
         repeat (hi) tick();
         sig_in = 1'b0;
         repeat (lo) tick();
      end
   endtask

   initial begin
      int hi;
      int lo;
      int reps;
      int act;
      int expHi5;
      int expHi3;
`ifdef CLK_PERIOD_METER_DUTY_EN
      expHi5 = 5;
      expHi3 = 3;
`else
      expHi5 = 0;
      expHi3 = 0;
`endif
      $display("[TB] start");
      repeat (3) tick();
      checkOutput("reset_period", 32'(period), 32'd0);
      checkOutput("reset_high", 32'(high_time), 32'd0);
      checkOutput("reset_valid", 32'(valid), 32'd0);
      checkOutput("reset_timeout", 32'(timeout), 32'd0);
      rst_n = 1'b1;
      tick();
      en = 1'b1;

      // Divide-by-10 square wave
      applyStimulus(5, 5, 3);
      validSeen = 0;
      applyStimulus(5, 5, 10);
      checkOutput("div10_valid_count", 32'(validSeen), 32'd10);
      checkOutput("div10_period", 32'(period), 32'd10);
      checkOutput("div10_high", 32'(high_time), 32'(expHi5));

      // Divide-by-7, 3 high / 4 low
      applyStimulus(3, 4, 3);
      checkOutput("div7_period", 32'(period), 32'd7);
      checkOutput("div7_high", 32'(high_time), 32'(expHi3));

      // Input stuck low until timeout, then resume
      applyStimulus(3, 4, 2);
      validSeen = 0;
      repeat (TO + 8) tick();
      checkOutput("stuck_timeout", 32'(timeout), 32'd1);
      checkOutput("stuck_no_valid", 32'(validSeen), 32'd0);
      checkOutput("stuck_period_kept", 32'(period), 32'd7);
      applyStimulus(3, 4, 3);
      checkOutput("resume_timeout_clear", 32'(timeout), 32'd0);

      // Enable dropped during the low phase
      applyStimulus(5, 5, 2);
      sig_in = 1'b1;
      repeat (5) tick();
      sig_in = 1'b0;
      repeat (3) tick();
      en        = 1'b0;
      validSeen = 0;
      applyStimulus(5, 5, 3);
      checkOutput("en_off_no_valid", 32'(validSeen), 32'd0);
      checkOutput("en_off_period_kept", 32'(period), 32'd10);
      en        = 1'b1;
      validSeen = 0;
      applyStimulus(5, 5, 3);
      checkOutput("en_on_valid_count", 32'(validSeen), 32'd2);

      // Reset pulsed during the high phase
      applyStimulus(5, 5, 2);
      sig_in = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_period", 32'(period), 32'd0);
      checkOutput("async_rst_high", 32'(high_time), 32'd0);
      checkOutput("async_rst_valid", 32'(valid), 32'd0);
      checkOutput("async_rst_timeout", 32'(timeout), 32'd0);
      sig_in = 1'b0;
      repeat (2) tick();
      rst_n     = 1'b1;
      validSeen = 0;
      applyStimulus(5, 5, 3);
      checkOutput("post_rst_valid_count", 32'(validSeen), 32'd2);

      // Randomized patterns with occasional stalls, disables and resets
      for (int i = 0; i < 40; i++) begin
         hi   = int'($urandom_range(1, 12));
         lo   = int'($urandom_range(1, 12));
         reps = int'($urandom_range(1, 4));
         act  = int'($urandom_range(0, 15));
         applyStimulus(hi, lo, reps);
         if (act < 3) begin
            sig_in = 1'b0;
            repeat (TO + 5) tick();
         end else if (act < 5) begin
            en = 1'b0;
            repeat (int'($urandom_range(1, 3))) tick();
            en = 1'b1;
         end else if (act == 5) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
      end

      repeat (10) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter: CNT_W, default 16, width of every measurement counter and result.
REQ-002 Parameter: TIMEOUT, default 65535, clk_in cycles without a rising edge before a timeout is declared; legal range 2 .. 2^CNT_W-1.
REQ-003 Port: clk_in  input  1  sole clock; all state is on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: en  input  1  measurement enable, synchronous to clk_in.
REQ-006 Port: sig_in  input  1  measured square wave, asynchronous to clk_in.
REQ-007 Port: period  output  CNT_W  last measured period, in clk_in cycles.
REQ-008 Port: high_time  output  CNT_W  last measured high phase, in clk_in cycles.
REQ-009 Port: valid  output  1  one-cycle pulse when period/high_time update.
REQ-010 Port: timeout  output  1  sticky flag: no rising edge within TIMEOUT cycles.

Function
REQ-011 sig_in shall pass through a 2-flop synchronizer, then a 1-flop edge detector; edge-to-detection latency is 3 clk_in cycles, fixed.
REQ-012 States shall be IDLE, ARM, HIGH, LOW.
REQ-013 IDLE: counters held at 0; en=1 -> ARM next cycle.
REQ-014 ARM: wait for the first detected rising edge -> HIGH, with the counter loaded to 1; no result is published on this edge.
REQ-015 HIGH: counter increments each cycle; on a detected falling edge, high count latched internally -> LOW; counter continues.
REQ-016 LOW: counter increments each cycle; on a detected rising edge -> HIGH, with the counter reloaded to 1.
REQ-017 Publish on the LOW rising edge: period <= counter value, high_time <= latched high count, valid=1 for exactly that cycle.
REQ-018 period = number of clk_in cycles between consecutive detected rising edges; high_time = cycles from rise to fall.
REQ-019 A rising edge detected in HIGH (fall missed) shall be treated as a period with high_time equal to period.
REQ-020 Counter shall saturate at 2^CNT_W-1, never wrap.
REQ-021 In ARM/HIGH/LOW, when the counter reaches TIMEOUT without a rising edge: timeout <= 1 -> ARM; period/high_time keep their last values; no valid pulse.
REQ-022 timeout shall clear on the next valid pulse, or when en=0.
REQ-023 en=0 in any state shall force IDLE next cycle and discard the partial measurement; outputs keep their last values; valid=0.
REQ-024 en and a publishing edge in the same cycle with en=0 shall not publish.

Reset
REQ-025 rst_n low: state IDLE; period=0, high_time=0, valid=0, timeout=0; synchronizer and edge flops = 0.
REQ-026 Reset asserted mid-measurement shall abort immediately; the first result after release requires a fresh ARM edge.

Configuration
REQ-027 Macro CLK_PERIOD_METER_DUTY_EN defined: high-phase latch and high_time output implemented per REQ-015..019.
REQ-028 Macro undefined: no high latch logic; high_time tied to 0; HIGH/LOW still track the falling edge so period timing is unchanged.

Structure
REQ-029 The state enumeration and default CNT_W/TIMEOUT constants shall live in the shared package clk_meas_pkg.
REQ-030 The synchronizer plus edge detector shall be one sub-module, sync_edge (outputs rise, fall pulses).

Verification
REQ-031 sig_in from divider pattern DIV=10 (5 high, 5 low), en=1 -> after the first full period, valid every 10 cycles, period=10, high_time=5.
REQ-032 DIV=7 (3 high, 4 low) -> period=7, high_time=3; with the macro undefined -> period=7, high_time=0.
REQ-033 TIMEOUT=20, sig_in held low after two edges -> timeout=1 exactly 20 cycles after the last rise, no valid; resume toggling -> timeout clears on the next valid.
REQ-034 en dropped in cycle 4 of a LOW phase -> no valid, state IDLE, period unchanged; en re-raised -> first valid only after ARM edge plus one full period.
REQ-035 rst_n pulsed low mid-HIGH -> all outputs 0 asynchronously; after release with en=1, first valid only after ARM edge plus one full period.
